// File: rtl/ram_access_arbiter.sv
// Shares the single ram512x8 between the instruction-fetch port (I) and the
// load/store port (D). Each granted request becomes one registered RAM cycle
// (ram_en held until ram_finished or timeout) followed by a one-cycle response
// slot that carries the ack/err pulse and gives the RAM a recovery cycle.
module ram_access_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_err,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [31:0]       ram_data,
  output logic [1:0]        ram_size,
  output logic [1:0]        ram_place,
  input  logic [31:0]       ram_out,
  input  logic              ram_finished,
  output logic              busy
);

  localparam int               CNT_W     = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;

  state_e            state_q, state_d;
  port_e             grant_q, grant_d;
  port_e             last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              en_q, en_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        place_q, place_d;
  logic              i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  port_e pick;
  logic  d_bad;
  logic  pick_bad;

  // Arbitration and alignment check for whatever is requesting this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pick = PORT_I;
    if (d_req && (!i_req || last_grant_q == PORT_I)) pick = PORT_D;
    case (d_size)
      2'b00:   d_bad = 1'b0;
      2'b01:   d_bad = d_addr[0];
      2'b10:   d_bad = |d_addr[1:0];
      default: d_bad = 1'b1;
    endcase
    pick_bad = (pick == PORT_D) ? d_bad : |i_addr[1:0];
  end

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    en_d         = en_q;
    rw_d         = rw_q;
    adr_d        = adr_q;
    data_d       = data_q;
    size_d       = size_q;
    place_d      = place_q;
    i_ack_d      = 1'b0;
    i_err_d      = 1'b0;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          grant_d      = pick;
          last_grant_d = pick;
          if (pick_bad) begin
            // Misaligned or reserved size: answer straight away, no RAM cycle.
            state_d = S_RESP;
            if (pick == PORT_D) d_err_d = 1'b1;
            else                i_err_d = 1'b1;
          end else begin
            state_d = S_ACCESS;
            en_d    = 1'b1;
            cnt_d   = '0;
            if (pick == PORT_D) begin
              rw_d    = d_rw;
              adr_d   = {d_addr[ADDR_W-1:2], 2'b00};
              data_d  = d_wdata;
              size_d  = d_size;
              place_d = d_addr[1:0];
            end else begin
              rw_d    = 1'b1;
              adr_d   = {i_addr[ADDR_W-1:2], 2'b00};
              size_d  = SIZE_WORD;
              place_d = i_addr[1:0];
            end
          end
        end
      end

      S_ACCESS: begin
        if (ram_finished) begin
          // Completion beats a coincident timeout.
          en_d    = 1'b0;
          state_d = S_RESP;
          if (grant_q == PORT_D) begin
            d_ack_d = 1'b1;
            if (rw_q) d_rdata_d = ram_out;
          end else begin
            i_ack_d = 1'b1;
            if (rw_q) i_rdata_d = ram_out;
          end
        end else if (cnt_q == CNT_LAST) begin
          en_d    = 1'b0;
          state_d = S_RESP;
          if (grant_q == PORT_D) d_err_d = 1'b1;
          else                   i_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        // Single response/recovery cycle; requests are not looked at here.
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset also aborts any RAM cycle in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= PORT_I;
      last_grant_q <= PORT_I;
      cnt_q        <= '0;
      en_q         <= 1'b0;
      rw_q         <= 1'b1;
      adr_q        <= '0;
      data_q       <= '0;
      size_q       <= '0;
      place_q      <= '0;
      i_ack_q      <= 1'b0;
      i_err_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      en_q         <= en_d;
      rw_q         <= rw_d;
      adr_q        <= adr_d;
      data_q       <= data_d;
      size_q       <= size_d;
      place_q      <= place_d;
      i_ack_q      <= i_ack_d;
      i_err_q      <= i_err_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign ram_en    = en_q;
  assign ram_rw    = rw_q;
  assign ram_adr   = adr_q;
  assign ram_data  = data_q;
  assign ram_size  = size_q;
  assign ram_place = place_q;
  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter: a small byte-addressed RAM model
// with programmable completion latency, a table of D-port transactions, and
// hand-written sequences for arbitration ties, I-port errors and mid-access reset.
module tb_ram_access_arbiter;

  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_ack, i_err;
  logic [31:0]       i_rdata;
  logic              d_req = 1'b0;
  logic              d_rw = 1'b1;
  logic [1:0]        d_size = 2'b00;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [31:0]       d_wdata = '0;
  logic              d_ack, d_err;
  logic [31:0]       d_rdata;
  logic              ram_en, ram_rw;
  logic [ADDR_W-1:0] ram_adr;
  logic [31:0]       ram_data;
  logic [1:0]        ram_size, ram_place;
  logic [31:0]       ram_out;
  logic              ram_finished;
  logic              busy;

  always #5 clk = ~clk;

  ram_access_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_adr(ram_adr), .ram_data(ram_data),
    .ram_size(ram_size), .ram_place(ram_place), .ram_out(ram_out),
    .ram_finished(ram_finished), .busy(busy)
  );

  // ---------------- RAM model: finishes in the ram_lat-th enabled cycle (0 = never)
  logic [7:0] mem [0:511];
  int         ram_lat = 1;
  int         en_cnt = 0;
  logic [8:0] rb;

  assign ram_finished = ram_en && (ram_lat != 0) && (en_cnt == ram_lat - 1);

  always_comb begin
    rb = ram_adr + 9'(ram_place);
    case (ram_size)
      2'b00:   ram_out = {24'h0, mem[rb]};
      2'b01:   ram_out = {16'h0, mem[rb + 9'd1], mem[rb]};
      default: ram_out = {mem[rb + 9'd3], mem[rb + 9'd2], mem[rb + 9'd1], mem[rb]};
    endcase
  end

  always @(posedge clk) begin
    en_cnt <= (ram_en && !ram_finished) ? en_cnt + 1 : 0;
    if (ram_en && ram_finished && !ram_rw) begin
      mem[rb] <= ram_data[7:0];
      if (ram_size != 2'b00) mem[rb + 9'd1] <= ram_data[15:8];
      if (ram_size == 2'b10) begin
        mem[rb + 9'd2] <= ram_data[23:16];
        mem[rb + 9'd3] <= ram_data[31:24];
      end
    end
  end

  // ---------------- protocol monitor
  int n_i_ack = 0, n_d_ack = 0, n_viol = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (i_ack) n_i_ack++;
      if (d_ack) n_d_ack++;
      if ((i_ack && i_err) || (d_ack && d_err) ||
          ((i_ack || i_err) && (d_ack || d_err)) ||
          ((i_ack || i_err || d_ack || d_err) && ram_en))
        n_viol++;
    end
  end

  // ---------------- checking
  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Observation of one transaction (filled in by wait_txn)
  int                n_cyc, n_en;
  bit                done, unstable;
  logic              got_i_ack, got_i_err, got_d_ack, got_d_err;
  logic [ADDR_W-1:0] o_adr;
  logic [1:0]        o_place, o_size;
  logic              o_rw;
  logic [31:0]       o_data;

  task automatic wait_txn();
    n_cyc = 0; n_en = 0; done = 0; unstable = 0;
    got_i_ack = 0; got_i_err = 0; got_d_ack = 0; got_d_err = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      n_cyc++;
      if (ram_en) begin
        if (n_en == 0) begin
          o_adr = ram_adr; o_place = ram_place; o_size = ram_size; o_rw = ram_rw; o_data = ram_data;
        end else if ({ram_adr, ram_place, ram_size, ram_rw, ram_data} !==
                     {o_adr, o_place, o_size, o_rw, o_data}) begin
          unstable = 1;
        end
        n_en++;
      end
      got_i_ack = i_ack; got_i_err = i_err; got_d_ack = d_ack; got_d_err = d_err;
      done = i_ack || i_err || d_ack || d_err;
    end
    check("txn_completes", done, 1'b1);
  endtask

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic [8:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic        exp_ack;
    int          exp_cyc;
    int          exp_en;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [17];
  int   snap_i, snap_d;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = 8'h00;

    // ---- reset state
    repeat (2) @(negedge clk);
    check("rst_ram_en", ram_en, 1'b0);
    check("rst_ram_rw", ram_rw, 1'b1);
    check("rst_ram_fields", {ram_adr, ram_data, ram_size, ram_place}, '0);
    check("rst_acks", {i_ack, i_err, d_ack, d_err}, 4'b0000);
    check("rst_rdata", {i_rdata, d_rdata}, 64'h0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- D-port vector table: {rw, size, addr, wdata, lat, ack, cycles, en cycles, d_rdata after}
    vecs[0]  = '{1'b0, 2'b10, 9'h004, 32'h0000_0003, 2, 1'b1, 3,  2,  32'h0000_0000};
    vecs[1]  = '{1'b0, 2'b00, 9'h000, 32'h0000_0003, 1, 1'b1, 2,  1,  32'h0000_0000};
    vecs[2]  = '{1'b0, 2'b00, 9'h001, 32'h0000_0004, 3, 1'b1, 4,  3,  32'h0000_0000};
    vecs[3]  = '{1'b0, 2'b00, 9'h002, 32'h0000_0005, 1, 1'b1, 2,  1,  32'h0000_0000};
    vecs[4]  = '{1'b0, 2'b00, 9'h003, 32'h0000_0006, 2, 1'b1, 3,  2,  32'h0000_0000};
    vecs[5]  = '{1'b1, 2'b00, 9'h000, 32'h0,         2, 1'b1, 3,  2,  32'h0000_0003};
    vecs[6]  = '{1'b1, 2'b00, 9'h001, 32'h0,         1, 1'b1, 2,  1,  32'h0000_0004};
    vecs[7]  = '{1'b1, 2'b00, 9'h002, 32'h0,         1, 1'b1, 2,  1,  32'h0000_0005};
    vecs[8]  = '{1'b1, 2'b00, 9'h003, 32'h0,         2, 1'b1, 3,  2,  32'h0000_0006};
    vecs[9]  = '{1'b1, 2'b10, 9'h004, 32'h0,         2, 1'b1, 3,  2,  32'h0000_0003};
    vecs[10] = '{1'b1, 2'b01, 9'h002, 32'h0,         1, 1'b1, 2,  1,  32'h0000_0605};
    vecs[11] = '{1'b0, 2'b01, 9'h001, 32'h0000_00AB, 1, 1'b0, 1,  0,  32'h0000_0605};
    vecs[12] = '{1'b0, 2'b10, 9'h002, 32'h1234_5678, 1, 1'b0, 1,  0,  32'h0000_0605};
    vecs[13] = '{1'b1, 2'b11, 9'h000, 32'h0,         1, 1'b0, 1,  0,  32'h0000_0605};
    vecs[14] = '{1'b1, 2'b10, 9'h000, 32'h0,         2, 1'b1, 3,  2,  32'h0605_0403};
    vecs[15] = '{1'b1, 2'b10, 9'h008, 32'h0,         0, 1'b0, 17, 16, 32'h0605_0403};
    vecs[16] = '{1'b1, 2'b00, 9'h004, 32'h0,         1, 1'b1, 2,  1,  32'h0000_0003};

    for (int v = 0; v < 17; v++) begin
      ram_lat = vecs[v].lat;
      d_rw = vecs[v].rw; d_size = vecs[v].size; d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
      d_req = 1'b1;
      wait_txn();
      d_req = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_ack", v), got_d_ack, vecs[v].exp_ack);
      check($sformatf("v%0d_err", v), got_d_err, !vecs[v].exp_ack);
      check($sformatf("v%0d_cycles", v), n_cyc, vecs[v].exp_cyc);
      check($sformatf("v%0d_en_cycles", v), n_en, vecs[v].exp_en);
      check($sformatf("v%0d_d_rdata", v), d_rdata, vecs[v].exp_rdata);
      check($sformatf("v%0d_i_quiet", v), {got_i_ack, got_i_err}, 2'b00);
      if (n_en > 0) begin
        check($sformatf("v%0d_ram_adr", v), o_adr, {vecs[v].addr[8:2], 2'b00});
        check($sformatf("v%0d_ram_place", v), o_place, vecs[v].addr[1:0]);
        check($sformatf("v%0d_ram_size", v), o_size, vecs[v].size);
        check($sformatf("v%0d_ram_rw", v), o_rw, vecs[v].rw);
        check($sformatf("v%0d_stable", v), unstable, 1'b0);
        if (!vecs[v].rw) check($sformatf("v%0d_ram_data", v), o_data, vecs[v].wdata);
      end
    end

    // ---- tie-break: both held across 4 transactions after reset -> D, I, D, I
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    snap_i = n_i_ack; snap_d = n_d_ack;
    ram_lat = 1;
    i_addr = 9'h004;
    d_rw = 1'b1; d_size = 2'b10; d_addr = 9'h000;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_txn();
      check($sformatf("tie%0d_d_granted", k), got_d_ack, (k % 2 == 0));
      check($sformatf("tie%0d_i_granted", k), got_i_ack, (k % 2 == 1));
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("tie_i_ack_count", n_i_ack - snap_i, 2);
    check("tie_d_ack_count", n_d_ack - snap_d, 2);
    check("tie_i_rdata", i_rdata, 32'h0000_0003);
    check("tie_d_rdata", d_rdata, 32'h0605_0403);

    // ---- I port: misaligned fetch errors without a RAM cycle, aligned fetch is a word read
    i_addr = 9'h002; i_req = 1'b1;
    wait_txn();
    i_req = 1'b0;
    @(negedge clk);
    check("i_mis_err", {got_i_ack, got_i_err, got_d_ack, got_d_err}, 4'b0100);
    check("i_mis_en_cycles", n_en, 0);
    check("i_mis_cycles", n_cyc, 1);
    i_addr = 9'h000; i_req = 1'b1; ram_lat = 2;
    wait_txn();
    i_req = 1'b0;
    @(negedge clk);
    check("i_fetch_ack", {got_i_ack, got_i_err}, 2'b10);
    check("i_fetch_rw_size", {o_rw, o_size}, 3'b110);
    check("i_fetch_rdata", i_rdata, 32'h0605_0403);

    // ---- reset in the middle of an access that never finishes
    snap_d = n_d_ack;
    ram_lat = 0;
    d_rw = 1'b1; d_size = 2'b10; d_addr = 9'h000; d_req = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_pre_en", ram_en, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ram_en", ram_en, 1'b0);
    check("mid_rst_ram_rw", ram_rw, 1'b1);
    check("mid_rst_fields", {ram_adr, ram_data, ram_size, ram_place}, '0);
    check("mid_rst_rdata", {i_rdata, d_rdata}, 64'h0);
    check("mid_rst_busy_acks", {busy, i_ack, i_err, d_ack, d_err}, 5'b00000);
    d_req = 1'b0; ram_lat = 1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_ack", n_d_ack - snap_d, 0);
    d_size = 2'b00; d_addr = 9'h003; d_req = 1'b1;
    wait_txn();
    d_req = 1'b0;
    @(negedge clk);
    check("post_rst_read", {got_d_ack, d_rdata}, {1'b1, 32'h0000_0006});

    check("protocol_violations", n_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
